// File: rtl/sevseg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display, with a minimum dwell per word.
// Optional macro SEVSEG_PREEMPT_EN lets requester 0 (CPU) cut short another requester's dwell.
module sevseg_display_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int SRC_W        = 2,
   parameter int DWELL_CYCLES = 100000000,
   parameter int CNT_W        = 27
) (
   input  logic                   clk_100MHz,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [32*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic [31:0]            disp_data,
   output logic                   disp_valid,
   output logic [SRC_W-1:0]       active_src,
   output logic                   busy
);

   typedef enum logic {IDLE, DWELL} state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]        disp_data_q, disp_data_d;
   logic               disp_valid_q, disp_valid_d;
   logic [SRC_W-1:0]   active_src_q, active_src_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               busy_q, busy_d;

   logic               found;
   logic [SRC_W-1:0]   sel;
   logic               grant;
   logic [SRC_W-1:0]   gnt_src;

   // First set request bit at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            found = 1'b1;
            sel   = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rr_ptr_d     = rr_ptr_q;
      disp_data_d  = disp_data_q;
      disp_valid_d = disp_valid_q;
      active_src_d = active_src_q;
      ack_d        = '0;
      busy_d       = busy_q;
      grant        = 1'b0;
      gnt_src      = sel;

      case (state_q)
         IDLE: begin
            grant = found;
         end
         DWELL: begin
            // Expiry cycle arbitrates directly so back-to-back grants have no idle gap.
            if (cnt_q == '0) begin
               grant = found;
               if (!found) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
`ifdef SEVSEG_PREEMPT_EN
               if (req[0] && (active_src_q != '0)) begin
                  grant   = 1'b1;
                  gnt_src = '0;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant) begin
         disp_data_d  = req_data[32*gnt_src +: 32];
         active_src_d = gnt_src;
         ack_d        = NUM_REQ'(1) << gnt_src;
         disp_valid_d = 1'b1;
         busy_d       = 1'b1;
         cnt_d        = CNT_LOAD;
         rr_ptr_d     = SRC_W'((int'(gnt_src) + 1) % NUM_REQ);
         state_d      = DWELL;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rr_ptr_q     <= '0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
         active_src_q <= '0;
         ack_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
         active_src_q <= active_src_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
      end
   end

   assign ack        = ack_q;
   assign disp_data  = disp_data_q;
   assign disp_valid = disp_valid_q;
   assign active_src = active_src_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sevseg_display_arbiter.sv
// Scoreboard bench for sevseg_display_arbiter: a cycle-level reference model pushes expected
// grants and per-cycle display status; a monitor pops and compares on the opposite clock edge.
module tb_sevseg_display_arbiter;

   localparam int N = 4;
   localparam int D = 4;

   logic              clk = 1'b0;
   logic              rst_n_r;
   logic [N-1:0]      req_r;
   logic [32*N-1:0]   req_data_r;
   logic [N-1:0]      ack;
   logic [31:0]       disp_data;
   logic              disp_valid;
   logic [1:0]        active_src;
   logic              busy;

   sevseg_display_arbiter #(
      .NUM_REQ(N), .SRC_W(2), .DWELL_CYCLES(D), .CNT_W(27)
   ) dut (
      .clk_100MHz(clk),
      .rst_n(rst_n_r),
      .req(req_r),
      .req_data(req_data_r),
      .ack(ack),
      .disp_data(disp_data),
      .disp_valid(disp_valid),
      .active_src(active_src),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          src;
      logic [31:0] data;
   } grant_t;

   typedef struct {
      logic [N-1:0] ack;
      logic [31:0]  data;
      logic         valid;
      logic [1:0]   src;
      logic         busy;
   } status_t;

   grant_t  gq[$];
   status_t sq[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit hold_mode;

   // Reference model state: time since the last grant, not a down-counter.
   int          m_ptr;
   int          m_elapsed;
   bit          m_in_dwell;
   logic [31:0] m_data;
   bit          m_valid;
   int          m_src;
   bit          m_busy;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      status_t s;
      grant_t  g;
      bit      can;
      int      sel;
      cyc++;
      s.ack = '0;
      if (!rst_n_r) begin
         m_ptr = 0; m_elapsed = 0; m_in_dwell = 0;
         m_data = '0; m_valid = 0; m_src = 0; m_busy = 0;
      end else begin
         if (m_in_dwell) m_elapsed++;
         can = !m_in_dwell || (m_elapsed >= D);
         sel = -1;
`ifdef SEVSEG_PREEMPT_EN
         if (!can && req_r[0] && m_src != 0) sel = 0;
`endif
         if (sel < 0 && can) begin
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (sel < 0 && req_r[j]) sel = j;
            end
         end
         if (sel >= 0) begin
            m_data = req_data_r[32*sel +: 32];
            m_src = sel; m_valid = 1; m_busy = 1;
            m_in_dwell = 1; m_elapsed = 0;
            m_ptr = (sel + 1) % N;
            s.ack = N'(1) << sel;
            g.cyc = cyc; g.src = sel; g.data = m_data;
            gq.push_back(g);
         end else if (can) begin
            m_in_dwell = 0;
            m_busy = 0;
         end
      end
      s.data = m_data; s.valid = m_valid; s.src = 2'(m_src); s.busy = m_busy;
      sq.push_back(s);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (ack[i]) begin
            if (hold_mode) req_data_r[32*i +: 32] = $urandom;
            else           req_r[i] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      status_t s;
      grant_t  g;
      if (sq.size() > 0) begin
         s = sq.pop_front();
         chk("ack", 32'(ack), 32'(s.ack));
         chk("disp_data", disp_data, s.data);
         chk("disp_valid", 32'(disp_valid), 32'(s.valid));
         chk("active_src", 32'(active_src), 32'(s.src));
         chk("busy", 32'(busy), 32'(s.busy));
      end
      if (ack != '0) begin
         if (gq.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'h0);
         end else begin
            g = gq.pop_front();
            chk("grant_cycle", 32'(cyc), 32'(g.cyc));
            chk("grant_src", 32'(ack), 32'(N'(1) << g.src));
            chk("grant_data", disp_data, g.data);
         end
      end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
         g = gq.pop_front();
         chk("missed_grant", 32'(ack), 32'(N'(1) << g.src));
      end
   end

   initial begin
      rst_n_r = 1'b0;
      hold_mode = 1'b0;
      req_r = '1;
      for (int i = 0; i < N; i++) req_data_r[32*i +: 32] = $urandom;
      repeat (3) tick();

      // all requesters held: rotation 0,1,2,3,0 with no idle gap
      rst_n_r = 1'b1;
      hold_mode = 1'b1;
      repeat (22) tick();

      // single request, value stays shown after the dwell
      rst_n_r = 1'b0; req_r = '0; tick();
      rst_n_r = 1'b1; tick();
      hold_mode = 1'b0;
      req_data_r[95:64] = 32'hDEADBEEF;
      req_r = 4'b0100;
      repeat (10) tick();

      // late requester joins one cycle into a dwell of requester 3
      req_r = 4'b1000; tick();
      tick();
      req_r[1] = 1'b1; req_data_r[63:32] = $urandom;
      repeat (8) tick();

      // reset mid-dwell, then requester 1 alone
      req_r = 4'b0001; req_data_r[31:0] = $urandom; tick();
      tick();
      rst_n_r = 1'b0; req_r = 4'b0010; req_data_r[63:32] = $urandom; tick();
      rst_n_r = 1'b1;
      repeat (6) tick();

      // requester 0 arrives two cycles into the dwell of requester 2
      req_r = 4'b0100; req_data_r[95:64] = $urandom; tick();
      tick(); tick();
      req_r[0] = 1'b1; req_data_r[31:0] = $urandom;
      repeat (10) tick();

      repeat (3000) begin
         rst_n_r = ($urandom_range(0, 199) != 0);
         hold_mode = $urandom_range(0, 1);
         for (int i = 0; i < N; i++) begin
            if (!req_r[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_r[i] = 1'b1;
                  req_data_r[32*i +: 32] = $urandom;
               end
            end else if ($urandom_range(0, 31) == 0) begin
               req_r[i] = 1'b0;
            end
         end
         tick();
      end

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
